// File: rtl/spi_rdid_slave_if.sv
// rtl/spi_rdid_slave_if.sv - SPI pins plus command sideband of the RDID responder
interface spi_rdid_slave_if;
    logic       SPICLK;
    logic       SPIMOSI;
    logic       chip_select;
    logic       SPIMISO;
    logic [7:0] cmd_byte;
    logic       cmd_strobe;
    logic       busy;

    modport master (
        output SPICLK, SPIMOSI, chip_select,
        input  SPIMISO, cmd_byte, cmd_strobe, busy
    );

    modport slave (
        input  SPICLK, SPIMOSI, chip_select,
        output SPIMISO, cmd_byte, cmd_strobe, busy
    );
endinterface

// File: rtl/spi_rdid_slave.sv
// rtl/spi_rdid_slave.sv - oversampled SPI mode-0 JEDEC ID responder; SPI_RDID_SLAVE_RDSR_EN adds RDSR (0x05)
module spi_rdid_slave #(
    parameter logic [7:0] MANUF_ID = 8'h20,
    parameter logic [7:0] MEM_TYPE = 8'h20,
    parameter logic [7:0] MEM_CAP  = 8'h15
) (
    input logic           clk,
    input logic           reset,
    spi_rdid_slave_if.slave spi
`ifdef SPI_RDID_SLAVE_RDSR_EN
    ,
    input logic [7:0]     status_reg
`endif
);
    localparam logic [23:0] ID_WORD = {MANUF_ID, MEM_TYPE, MEM_CAP};

    typedef enum logic [2:0] {SYNC_WAIT, IDLE, CMD, RESP, IGNORE} state_t;

    state_t      state_q, state_d;
    logic        sclk_meta_q, sclk_sync_q, sclk_prev_q;
    logic        mosi_meta_q, mosi_sync_q;
    logic        cs_meta_q, cs_sync_q, cs_prev_q;
    logic [1:0]  settle_q, settle_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  cmd_shift_q, cmd_shift_d;
    logic [23:0] id_shift_q, id_shift_d;
    logic        miso_q, miso_d;
    logic [7:0]  cmd_byte_q, cmd_byte_d;
    logic        strobe_q, strobe_d;

    logic        sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic [7:0]  cmd_next;
    logic        is_rdid, is_rdsr;
    logic [4:0]  resp_last;
    logic [23:0] reload;

    assign sclk_rise = sclk_sync_q & ~sclk_prev_q;
    assign sclk_fall = ~sclk_sync_q & sclk_prev_q;
    assign cs_rise   = cs_sync_q & ~cs_prev_q;
    assign cs_fall   = ~cs_sync_q & cs_prev_q;
    assign cmd_next  = {cmd_shift_q[6:0], mosi_sync_q};
    assign is_rdid   = (cmd_next == 8'h9F);

`ifdef SPI_RDID_SLAVE_RDSR_EN
    logic rdsr_q, rdsr_d;
    assign is_rdsr   = (cmd_next == 8'h05);
    assign resp_last = rdsr_q ? 5'd7 : 5'd23;
    assign reload    = rdsr_q ? {status_reg, 16'h0000} : ID_WORD;
`else
    assign is_rdsr   = 1'b0;
    assign resp_last = 5'd23;
    assign reload    = ID_WORD;
`endif

    // chip_select flops reset high so busy reads 0 during and right after reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= SYNC_WAIT;
            sclk_meta_q <= 1'b0;
            sclk_sync_q <= 1'b0;
            sclk_prev_q <= 1'b0;
            mosi_meta_q <= 1'b0;
            mosi_sync_q <= 1'b0;
            cs_meta_q   <= 1'b1;
            cs_sync_q   <= 1'b1;
            cs_prev_q   <= 1'b1;
            settle_q    <= 2'd0;
            bit_cnt_q   <= 5'd0;
            cmd_shift_q <= 8'h00;
            id_shift_q  <= 24'h000000;
            miso_q      <= 1'b0;
            cmd_byte_q  <= 8'h00;
            strobe_q    <= 1'b0;
`ifdef SPI_RDID_SLAVE_RDSR_EN
            rdsr_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            sclk_meta_q <= spi.SPICLK;
            sclk_sync_q <= sclk_meta_q;
            sclk_prev_q <= sclk_sync_q;
            mosi_meta_q <= spi.SPIMOSI;
            mosi_sync_q <= mosi_meta_q;
            cs_meta_q   <= spi.chip_select;
            cs_sync_q   <= cs_meta_q;
            cs_prev_q   <= cs_sync_q;
            settle_q    <= settle_d;
            bit_cnt_q   <= bit_cnt_d;
            cmd_shift_q <= cmd_shift_d;
            id_shift_q  <= id_shift_d;
            miso_q      <= miso_d;
            cmd_byte_q  <= cmd_byte_d;
            strobe_q    <= strobe_d;
`ifdef SPI_RDID_SLAVE_RDSR_EN
            rdsr_q      <= rdsr_d;
`endif
        end
    end

    // SYNC_WAIT lets the synchronizers flush before trusting a high chip_select
    always_comb begin
        state_d = state_q;
        case (state_q)
            SYNC_WAIT: if (settle_q == 2'd2 && cs_sync_q) state_d = IDLE;
            IDLE:      if (cs_fall) state_d = CMD;
            CMD: begin
                if (cs_rise)
                    state_d = IDLE;
                else if (sclk_rise && bit_cnt_q == 5'd7)
                    state_d = (is_rdid || is_rdsr) ? RESP : IGNORE;
            end
            RESP, IGNORE: if (cs_rise) state_d = IDLE;
            default:   state_d = SYNC_WAIT;
        endcase
    end

    always_comb begin
        settle_d    = settle_q;
        bit_cnt_d   = bit_cnt_q;
        cmd_shift_d = cmd_shift_q;
        id_shift_d  = id_shift_q;
        miso_d      = miso_q;
        cmd_byte_d  = cmd_byte_q;
        strobe_d    = 1'b0;
`ifdef SPI_RDID_SLAVE_RDSR_EN
        rdsr_d      = rdsr_q;
`endif
        case (state_q)
            SYNC_WAIT: begin
                miso_d = 1'b0;
                if (settle_q != 2'd2) settle_d = settle_q + 2'd1;
            end
            IDLE: begin
                miso_d      = 1'b0;
                bit_cnt_d   = 5'd0;
                cmd_shift_d = 8'h00;
            end
            CMD: begin
                if (cs_rise) begin
                    miso_d    = 1'b0;
                    bit_cnt_d = 5'd0;
                end else if (sclk_rise) begin
                    cmd_shift_d = cmd_next;
                    if (bit_cnt_q == 5'd7) begin
                        cmd_byte_d = cmd_next;
                        strobe_d   = 1'b1;
                        bit_cnt_d  = 5'd0;
                        id_shift_d = ID_WORD;
`ifdef SPI_RDID_SLAVE_RDSR_EN
                        rdsr_d = is_rdsr;
                        if (is_rdsr) id_shift_d = {status_reg, 16'h0000};
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
            end
            RESP: begin
                if (cs_rise) begin
                    miso_d    = 1'b0;
                    bit_cnt_d = 5'd0;
                end else if (sclk_fall) begin
                    miso_d = id_shift_q[23];
                    if (bit_cnt_q == resp_last) begin
                        id_shift_d = reload;
                        bit_cnt_d  = 5'd0;
                    end else begin
                        id_shift_d = {id_shift_q[22:0], 1'b0};
                        bit_cnt_d  = bit_cnt_q + 5'd1;
                    end
                end
            end
            IGNORE: begin
                miso_d = 1'b0;
                if (cs_rise) bit_cnt_d = 5'd0;
            end
            default: miso_d = 1'b0;
        endcase
    end

    assign spi.SPIMISO    = miso_q;
    assign spi.cmd_byte   = cmd_byte_q;
    assign spi.cmd_strobe = strobe_q;
    assign spi.busy       = ~cs_sync_q;
endmodule

// File: tb/tb_spi_rdid_slave.sv
// tb/tb_spi_rdid_slave.sv - directed self-checking bench for spi_rdid_slave
`timescale 1ns/1ps
module tb_spi_rdid_slave;
    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   strobe_cnt;

    spi_rdid_slave_if bus ();

`ifdef SPI_RDID_SLAVE_RDSR_EN
    logic [7:0] status_reg;
    spi_rdid_slave dut (.clk(clk), .reset(reset), .spi(bus.slave), .status_reg(status_reg));
`else
    spi_rdid_slave dut (.clk(clk), .reset(reset), .spi(bus.slave));
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (bus.cmd_strobe === 1'b1) strobe_cnt++;

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // SPICLK period is 12 clk; MISO is sampled just before each rising edge
    task automatic spi_bit(input logic mo, output logic mi);
        bus.SPIMOSI = mo;
        wait_clk(6);
        mi = bus.SPIMISO;
        bus.SPICLK = 1'b1;
        wait_clk(6);
        bus.SPICLK = 1'b0;
    endtask

    task automatic send_cmd(input logic [7:0] cmd, input int nbits);
        logic d;
        for (int i = 0; i < nbits; i++) spi_bit(cmd[7-i], d);
    endtask

    task automatic read_bits(input int n, output logic [47:0] resp);
        logic b;
        resp = '0;
        for (int i = 0; i < n; i++) begin
            spi_bit(1'b0, b);
            resp = {resp[46:0], b};
        end
    endtask

    task automatic run_frame(input logic [7:0] cmd, input int nresp, output logic [47:0] resp);
        bus.chip_select = 1'b0;
        wait_clk(6);
        send_cmd(cmd, 8);
        read_bits(nresp, resp);
        wait_clk(6);
        bus.chip_select = 1'b1;
        wait_clk(10);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        bus.chip_select = 1'b1;
        bus.SPICLK = 1'b0;
        bus.SPIMOSI = 1'b0;
        wait_clk(3);
        checks++;
        if (bus.SPIMISO !== 1'b0 || bus.busy !== 1'b0 || bus.cmd_strobe !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: miso=%b busy=%b strobe=%b, required 0 0 0", bus.SPIMISO, bus.busy, bus.cmd_strobe);
        end
        checks++;
        if (bus.cmd_byte !== 8'h00) begin
            errors++;
            $display("FAIL reset_cmd_byte: got %h, required 00", bus.cmd_byte);
        end
        reset = 1'b0;
        wait_clk(10);
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_busy: got %b, required 0", bus.busy);
        end
    endtask

    task automatic test_busy;
        bus.chip_select = 1'b0;
        wait_clk(6);
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_low_cs: got %b, required 1", bus.busy);
        end
        bus.chip_select = 1'b1;
        wait_clk(6);
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_high_cs: got %b, required 0", bus.busy);
        end
        wait_clk(6);
    endtask

    task automatic test_rdid;
        logic [47:0] r;
        strobe_cnt = 0;
        run_frame(8'h9F, 24, r);
        checks++;
        if (r[23:0] !== 24'h202015) begin
            errors++;
            $display("FAIL rdid_id: got %h, required 202015", r[23:0]);
        end
        checks++;
        if (bus.cmd_byte !== 8'h9F || strobe_cnt != 1) begin
            errors++;
            $display("FAIL rdid_cmd: cmd_byte=%h strobes=%0d, required 9f 1", bus.cmd_byte, strobe_cnt);
        end
    endtask

    task automatic test_wrap;
        logic [47:0] r;
        run_frame(8'h9F, 48, r);
        checks++;
        if (r[47:24] !== 24'h202015) begin
            errors++;
            $display("FAIL wrap_first: got %h, required 202015", r[47:24]);
        end
        checks++;
        if (r[23:0] !== 24'h202015) begin
            errors++;
            $display("FAIL wrap_second: got %h, required 202015", r[23:0]);
        end
    endtask

    task automatic test_ignore;
        logic [47:0] r;
        strobe_cnt = 0;
        run_frame(8'h03, 16, r);
        checks++;
        if (r[15:0] !== 16'h0000) begin
            errors++;
            $display("FAIL ignore_miso: got %h, required 0000", r[15:0]);
        end
        checks++;
        if (bus.cmd_byte !== 8'h03 || strobe_cnt != 1) begin
            errors++;
            $display("FAIL ignore_cmd: cmd_byte=%h strobes=%0d, required 03 1", bus.cmd_byte, strobe_cnt);
        end
    endtask

    task automatic test_partial;
        logic [47:0] r;
        strobe_cnt = 0;
        bus.chip_select = 1'b0;
        wait_clk(6);
        send_cmd(8'h9F, 5);
        bus.chip_select = 1'b1;
        wait_clk(10);
        checks++;
        if (strobe_cnt != 0 || bus.cmd_byte !== 8'h03) begin
            errors++;
            $display("FAIL partial_cmd: strobes=%0d cmd_byte=%h, required 0 03", strobe_cnt, bus.cmd_byte);
        end
        run_frame(8'h9F, 24, r);
        checks++;
        if (r[23:0] !== 24'h202015 || strobe_cnt != 1) begin
            errors++;
            $display("FAIL partial_next: id=%h strobes=%0d, required 202015 1", r[23:0], strobe_cnt);
        end
    endtask

    task automatic test_reset_mid_frame;
        logic [47:0] r;
        bus.chip_select = 1'b0;
        wait_clk(6);
        reset = 1'b1;
        wait_clk(3);
        reset = 1'b0;
        strobe_cnt = 0;
        wait_clk(6);
        send_cmd(8'h9F, 8);
        read_bits(8, r);
        checks++;
        if (strobe_cnt != 0 || r[7:0] !== 8'h00 || bus.cmd_byte !== 8'h00) begin
            errors++;
            $display("FAIL joined_frame: strobes=%0d miso=%h cmd_byte=%h, required 0 00 00", strobe_cnt, r[7:0], bus.cmd_byte);
        end
        bus.chip_select = 1'b1;
        wait_clk(10);
        run_frame(8'h9F, 24, r);
        checks++;
        if (r[23:0] !== 24'h202015 || strobe_cnt != 1 || bus.cmd_byte !== 8'h9F) begin
            errors++;
            $display("FAIL after_sync: id=%h strobes=%0d cmd_byte=%h, required 202015 1 9f", r[23:0], strobe_cnt, bus.cmd_byte);
        end
        // two response bits (0,0) then the third (1) is on MISO when reset hits
        bus.chip_select = 1'b0;
        wait_clk(6);
        send_cmd(8'h9F, 8);
        read_bits(2, r);
        wait_clk(6);
        checks++;
        if (bus.SPIMISO !== 1'b1 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: miso=%b busy=%b, required 1 1", bus.SPIMISO, bus.busy);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if (bus.SPIMISO !== 1'b0 || bus.busy !== 1'b0 || bus.cmd_byte !== 8'h00) begin
            errors++;
            $display("FAIL async_reset: miso=%b busy=%b cmd_byte=%h, required 0 0 00", bus.SPIMISO, bus.busy, bus.cmd_byte);
        end
        wait_clk(2);
        bus.chip_select = 1'b1;
        reset = 1'b0;
        wait_clk(10);
    endtask

`ifdef SPI_RDID_SLAVE_RDSR_EN
    task automatic test_rdsr;
        logic [47:0] r;
        status_reg = 8'hA5;
        strobe_cnt = 0;
        run_frame(8'h05, 16, r);
        checks++;
        if (r[15:0] !== 16'hA5A5 || strobe_cnt != 1) begin
            errors++;
            $display("FAIL rdsr: got %h strobes=%0d, required a5a5 1", r[15:0], strobe_cnt);
        end
    endtask
`else
    task automatic test_rdsr;
        logic [47:0] r;
        strobe_cnt = 0;
        run_frame(8'h05, 16, r);
        checks++;
        if (r[15:0] !== 16'h0000 || strobe_cnt != 1 || bus.cmd_byte !== 8'h05) begin
            errors++;
            $display("FAIL rdsr_absent: got %h strobes=%0d cmd_byte=%h, required 0000 1 05", r[15:0], strobe_cnt, bus.cmd_byte);
        end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        strobe_cnt = 0;
`ifdef SPI_RDID_SLAVE_RDSR_EN
        status_reg = 8'h00;
`endif
        test_reset;
        test_busy;
        test_rdid;
        test_wrap;
        test_ignore;
        test_partial;
        test_reset_mid_frame;
        test_rdsr;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
